// File: rtl/lpc_pkg.sv
// Shared constants and processing-state encoding for the LPC frame scheduler.
package lpc_pkg;

    localparam int unsigned FRAME_LEN = 160;
    localparam int unsigned LPC_ORDER = 10;
    localparam int unsigned ADDR_W    = 8;

    typedef enum logic [1:0] {
        StIdle,
        StAc,
        StLd,
        StOut
    } lpc_state_e;

endpackage

// File: rtl/lpc_frame_scheduler_if.sv
// Handshake and control bundle between the LPC frame scheduler and its surroundings.
interface lpc_frame_scheduler_if #(
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             wr_en;
    logic             wr_bank;
    logic [7:0]       wr_addr;
    logic             ac_start;
    logic             ac_bank;
    logic             ac_done;
    logic             ld_start;
    logic             ld_done;
    logic             coef_valid;
    logic             coef_ready;
    logic             overrun;
    logic             busy;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        input  in_valid, ac_done, ld_done, coef_ready,
        output in_ready, wr_en, wr_bank, wr_addr, ac_start, ac_bank, ld_start,
               coef_valid, overrun, busy, frame_cnt
    );

    modport slave (
        output in_valid, ac_done, ld_done, coef_ready,
        input  in_ready, wr_en, wr_bank, wr_addr, ac_start, ac_bank, ld_start,
               coef_valid, overrun, busy, frame_cnt
    );

endinterface

// File: rtl/lpc_bank_writer.sv
// Fill side of the ping-pong sample RAM: write address, bank select, bank-full
// flags and overrun detection.
module lpc_bank_writer #(
    parameter int unsigned FRAME_LEN = 160
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       clr_en,
    input  logic       clr_bank,
    output logic       in_ready,
    output logic       wr_en,
    output logic       wr_bank,
    output logic [7:0] wr_addr,
    output logic       overrun,
    output logic [1:0] full
);
    import lpc_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [1:0]        full_q, full_d;
    logic              overrun_q, overrun_d;

    always_comb begin
        in_ready  = !full_q[wr_bank_q];
        wr_en     = in_valid && in_ready;
        wr_bank_d = wr_bank_q;
        wr_addr_d = wr_addr_q;
        full_d    = full_q;
        overrun_d = in_valid && !in_ready;

        // Clear and set never target the same bank, so applying both is safe.
        if (clr_en) begin
            full_d[clr_bank] = 1'b0;
        end
        if (wr_en) begin
            if (wr_addr_q == LAST_ADDR) begin
                wr_addr_d         = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end else begin
                wr_addr_d = wr_addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank_q <= 1'b0;
            wr_addr_q <= '0;
            full_q    <= 2'b00;
            overrun_q <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            wr_addr_q <= wr_addr_d;
            full_q    <= full_d;
            overrun_q <= overrun_d;
        end
    end

    assign wr_bank = wr_bank_q;
    assign wr_addr = wr_addr_q;
    assign overrun = overrun_q;
    assign full    = full_q;

endmodule

// File: rtl/lpc_frame_scheduler.sv
// Sequences autocorrelation, Levinson-Durbin and coefficient output for each
// filled sample bank while the bank writer keeps accepting samples.
module lpc_frame_scheduler #(
    parameter int unsigned FRAME_LEN = lpc_pkg::FRAME_LEN,
    parameter int unsigned CNT_W     = 16
) (
    input logic                   clk,
    input logic                   reset,
    lpc_frame_scheduler_if.master bus
);
    import lpc_pkg::*;

    lpc_state_e       state_q, state_d;
    logic             first_q;
    logic             ac_bank_q, ac_bank_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]       full;
    logic             clr_en;

    lpc_bank_writer #(
        .FRAME_LEN (FRAME_LEN)
    ) u_writer (
        .clk      (clk),
        .reset    (reset),
        .in_valid (bus.in_valid),
        .clr_en   (clr_en),
        .clr_bank (ac_bank_q),
        .in_ready (bus.in_ready),
        .wr_en    (bus.wr_en),
        .wr_bank  (bus.wr_bank),
        .wr_addr  (bus.wr_addr),
        .overrun  (bus.overrun),
        .full     (full)
    );

    always_comb begin
        state_d        = state_q;
        ac_bank_d      = ac_bank_q;
        frame_cnt_d    = frame_cnt_q;
        clr_en         = 1'b0;
        bus.ac_start   = 1'b0;
        bus.ld_start   = 1'b0;
        bus.coef_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (full[ac_bank_q]) begin
                    state_d = StAc;
                end
            end
            StAc: begin
                bus.ac_start = first_q;
                // ac_done still reflects the previous frame during the first cycle.
                if (!first_q && bus.ac_done) begin
                    state_d   = StLd;
                    clr_en    = 1'b1;
                    ac_bank_d = !ac_bank_q;
                end
            end
            StLd: begin
                bus.ld_start = first_q;
                if (bus.ld_done) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                bus.coef_valid = 1'b1;
                if (bus.coef_ready) begin
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            first_q     <= 1'b0;
            ac_bank_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            first_q     <= (state_d != state_q);
            ac_bank_q   <= ac_bank_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.ac_bank   = ac_bank_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.frame_cnt = frame_cnt_q;

endmodule
